// File: rtl/abies_cmd_pkg.sv
// Shared definitions for the command parser.
//   - opcode byte values carried in the first byte of each frame
//   - err_code_t: error classification reported on err_code
//   - state_t: parser state machine encoding
// Build option: CMD_PARSER_CHECKSUM_EN adds the CSUM state, which checks a
// trailing XOR checksum byte on WRITE frames.
package abies_cmd_pkg;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_WRITE = 8'h01;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_SHORT = 2'd1,
    ERR_LONG  = 2'd2,
    ERR_BAD   = 2'd3
  } err_code_t;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
`ifdef CMD_PARSER_CHECKSUM_EN
    CSUM,
`endif
    ISSUE,
    DRAIN
  } state_t;

endpackage

// File: rtl/cmd_parser.sv
// Command frame parser: turns decoded frame bytes into register writes.
// Frame: opcode, addr, DATA_BYTES data bytes (LSB first), and, when built
// with CMD_PARSER_CHECKSUM_EN, one XOR checksum byte over all prior bytes.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   i_data/i_valid/i_last - incoming byte stream; o_ready is the handshake
//   wr_en/wr_addr/wr_data - register write, completes on wr_en & wr_ready
//   wr_ready              - register file acceptance
//   frame_ok / err        - one-cycle pulses per good / bad frame
//   err_code              - classification of the most recent error
module cmd_parser
  import abies_cmd_pkg::*;
#(
  parameter int DATA_BYTES = 4,
  parameter int AW         = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              i_data,
  input  logic                    i_valid,
  input  logic                    i_last,
  output logic                    o_ready,
  output logic                    wr_en,
  output logic [AW-1:0]           wr_addr,
  output logic [8*DATA_BYTES-1:0] wr_data,
  input  logic                    wr_ready,
  output logic                    frame_ok,
  output logic                    err,
  output logic [1:0]              err_code
);

  localparam int DW = 8 * DATA_BYTES;

  state_t          state_reg, state_next;
  logic [AW-1:0]   addr_reg, addr_next;
  logic [DW-1:0]   data_reg, data_next, data_shift;
  logic [2:0]      cnt_reg, cnt_next;
  err_code_t       code_reg, code_next;
  err_code_t       drain_reg, drain_next;   // code to report when DRAIN ends
  err_code_t       bad_code;
  logic            ok, bad;
  logic            accept;
  logic            final_byte;
`ifdef CMD_PARSER_CHECKSUM_EN
  logic [7:0]      csum_reg, csum_next;
`endif

  assign accept     = i_valid & o_ready;
  assign final_byte = (cnt_reg == 3'(DATA_BYTES - 1));

  // New bytes enter at the top so the first data byte ends up least significant.
  generate
    if (DATA_BYTES == 1) begin : g_shift_one
      assign data_shift = i_data;
    end else begin : g_shift_many
      assign data_shift = {i_data, data_reg[DW-1:8]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      data_reg  <= '0;
      cnt_reg   <= '0;
      code_reg  <= ERR_NONE;
      drain_reg <= ERR_NONE;
`ifdef CMD_PARSER_CHECKSUM_EN
      csum_reg  <= '0;
`endif
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      cnt_reg   <= cnt_next;
      code_reg  <= code_next;
      drain_reg <= drain_next;
`ifdef CMD_PARSER_CHECKSUM_EN
      csum_reg  <= csum_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    cnt_next   = cnt_reg;
    drain_next = drain_reg;
    ok         = 1'b0;
    bad        = 1'b0;
    bad_code   = ERR_NONE;
`ifdef CMD_PARSER_CHECKSUM_EN
    csum_next  = csum_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (i_data == OP_NOP && i_last) begin
            ok = 1'b1;
          end else if (i_data == OP_WRITE && !i_last) begin
            state_next = ADDR;
`ifdef CMD_PARSER_CHECKSUM_EN
            csum_next  = i_data;
`endif
          end else if (i_data == OP_WRITE) begin
            // WRITE opcode alone is a truncated write frame
            bad      = 1'b1;
            bad_code = ERR_SHORT;
          end else if (i_last) begin
            bad      = 1'b1;
            bad_code = ERR_BAD;
          end else begin
            state_next = DRAIN;
            drain_next = ERR_BAD;
          end
        end
      end
      ADDR: begin
        if (accept) begin
          if (i_last) begin
            bad        = 1'b1;
            bad_code   = ERR_SHORT;
            state_next = IDLE;
          end else begin
            addr_next  = AW'(i_data);
            cnt_next   = '0;
            state_next = DATA;
`ifdef CMD_PARSER_CHECKSUM_EN
            csum_next  = csum_reg ^ i_data;
`endif
          end
        end
      end
      DATA: begin
        if (accept) begin
          data_next = data_shift;
          cnt_next  = cnt_reg + 3'd1;
`ifdef CMD_PARSER_CHECKSUM_EN
          csum_next = csum_reg ^ i_data;
`endif
          if (!final_byte) begin
            if (i_last) begin
              bad        = 1'b1;
              bad_code   = ERR_SHORT;
              state_next = IDLE;
            end
          end else begin
`ifdef CMD_PARSER_CHECKSUM_EN
            // The checksum byte is still owed, so last here means short.
            if (i_last) begin
              bad        = 1'b1;
              bad_code   = ERR_SHORT;
              state_next = IDLE;
            end else begin
              state_next = CSUM;
            end
`else
            if (i_last) begin
              state_next = ISSUE;
            end else begin
              state_next = DRAIN;
              drain_next = ERR_LONG;
            end
`endif
          end
        end
      end
`ifdef CMD_PARSER_CHECKSUM_EN
      CSUM: begin
        if (accept) begin
          if (!i_last) begin
            state_next = DRAIN;
            drain_next = ERR_LONG;
          end else if (i_data == csum_reg) begin
            state_next = ISSUE;
          end else begin
            bad        = 1'b1;
            bad_code   = ERR_BAD;
            state_next = IDLE;
          end
        end
      end
`endif
      ISSUE: begin
        if (wr_ready) begin
          ok         = 1'b1;
          state_next = IDLE;
        end
      end
      DRAIN: begin
        if (accept && i_last) begin
          bad        = 1'b1;
          bad_code   = drain_reg;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    code_next = bad ? bad_code : code_reg;
  end

  // Pulses are decoded from the current state and byte; masking with rst
  // keeps them quiet while reset is being applied.
  assign o_ready  = (state_reg != ISSUE);
  assign wr_en    = (state_reg == ISSUE);
  assign wr_addr  = addr_reg;
  assign wr_data  = data_reg;
  assign frame_ok = ok & ~rst;
  assign err      = bad & ~rst;
  assign err_code = code_reg;

endmodule

// File: tb/tb_cmd_parser.sv
// Directed scoreboard bench for cmd_parser (DATA_BYTES = 4).
// Expected frame outcomes are queued as each frame is driven; a negedge
// monitor pops and compares them whenever the DUT reports an outcome.
module tb_cmd_parser;

  localparam int EV_NOP = 0;
  localparam int EV_WR  = 1;
  localparam int EV_ERR = 2;
  localparam int EV_BOG = 3;

  typedef struct {
    int          kind;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [1:0]  code;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  i_data = 8'h00;
  logic        i_valid = 1'b0;
  logic        i_last = 1'b0;
  logic        o_ready;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_ready = 1'b1;
  logic        frame_ok;
  logic        err;
  logic [1:0]  err_code;

  int checks = 0;
  int errors = 0;

  exp_t       exp_q[$];
  logic [7:0] frm[$];

  logic       code_pending = 1'b0;
  logic [1:0] pend_code = 2'd0;

  cmd_parser dut (
    .clk      (clk),
    .rst      (rst),
    .i_data   (i_data),
    .i_valid  (i_valid),
    .i_last   (i_last),
    .o_ready  (o_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .frame_ok (frame_ok),
    .err      (err),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    exp_t e;
    int   kind;
    if (code_pending) begin
      checks++;
      assert (err_code === pend_code) else begin
        errors++;
        $error("FAIL err_code got %0d want %0d", err_code, pend_code);
      end
      code_pending = 1'b0;
    end
    if (!rst) begin
      checks++;
      assert (!(frame_ok === 1'b1 && err === 1'b1)) else begin
        errors++;
        $error("FAIL ok_and_err got frame_ok=%b err=%b want not both", frame_ok, err);
      end
    end
    if (frame_ok === 1'b1 || err === 1'b1 || (wr_en === 1'b1 && wr_ready === 1'b1)) begin
      if (err === 1'b1)                                   kind = EV_ERR;
      else if (wr_en && wr_ready && frame_ok)             kind = EV_WR;
      else if (frame_ok && !wr_en)                        kind = EV_NOP;
      else                                                kind = EV_BOG;
      $display("event kind=%0d wr_en=%b addr=%02h data=%08h frame_ok=%b err=%b",
               kind, wr_en, wr_addr, wr_data, frame_ok, err);
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_event got kind %0d want none", kind);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        assert (kind === e.kind) else begin
          errors++;
          $error("FAIL event_kind got %0d want %0d", kind, e.kind);
        end
        if (e.kind == EV_WR) begin
          checks++;
          assert (wr_addr === e.addr && wr_data === e.data) else begin
            errors++;
            $error("FAIL write got %02h/%08h want %02h/%08h", wr_addr, wr_data, e.addr, e.data);
          end
        end
        if (e.kind == EV_ERR) begin
          code_pending = 1'b1;
          pend_code    = e.code;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  function automatic void expect_ev(int kind, logic [7:0] a, logic [31:0] d, logic [1:0] c);
    exp_t e;
    e.kind = kind; e.addr = a; e.data = d; e.code = c;
    exp_q.push_back(e);
  endfunction

  // Called at posedge+1; returns at posedge+1 after the byte is accepted.
  task automatic send_byte(input logic [7:0] b, input logic last);
    logic rdy;
    int   n;
    i_data = b; i_last = last; i_valid = 1'b1;
    n = 0;
    rdy = 1'b0;
    while (!rdy && n < 50) begin
      @(negedge clk);
      rdy = o_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got no o_ready want byte %02h accepted", b);
    end
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0; i_last = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame();
    for (int k = 0; k < frm.size(); k++)
      send_byte(frm[k], k == frm.size() - 1);
  endtask

  task automatic build_write(input logic [7:0] a, input logic [31:0] d);
    logic [7:0] x;
    frm.delete();
    frm.push_back(8'h01);
    frm.push_back(a);
    for (int k = 0; k < 4; k++) frm.push_back(d[8*k +: 8]);
    x = 8'h00;
    foreach (frm[k]) x = x ^ frm[k];
`ifdef CMD_PARSER_CHECKSUM_EN
    frm.push_back(x);
`endif
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; assert (o_ready === 1'b1)   else begin errors++; $error("FAIL rst_o_ready got %b want 1", o_ready); end
    checks++; assert (wr_en === 1'b0)     else begin errors++; $error("FAIL rst_wr_en got %b want 0", wr_en); end
    checks++; assert (frame_ok === 1'b0)  else begin errors++; $error("FAIL rst_frame_ok got %b want 0", frame_ok); end
    checks++; assert (err === 1'b0)       else begin errors++; $error("FAIL rst_err got %b want 0", err); end
    checks++; assert (err_code === 2'd0)  else begin errors++; $error("FAIL rst_err_code got %0d want 0", err_code); end
    checks++; assert (wr_addr === 8'h00)  else begin errors++; $error("FAIL rst_wr_addr got %02h want 00", wr_addr); end
    checks++; assert (wr_data === 32'h0)  else begin errors++; $error("FAIL rst_wr_data got %08h want 0", wr_data); end
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic write, register file always ready
    wr_ready = 1'b1;
    build_write(8'h10, 32'h12345678);
    expect_ev(EV_WR, 8'h10, 32'h12345678, 2'd0);
    send_frame();
    idle(3);

    // Write stalled by wr_ready; a NOP byte waits behind it
    wr_ready = 1'b0;
    build_write(8'h20, 32'hA5A50F0F);
    expect_ev(EV_WR, 8'h20, 32'hA5A50F0F, 2'd0);
    expect_ev(EV_NOP, 8'h00, 32'h0, 2'd0);
    send_frame();
    i_data = 8'h00; i_last = 1'b1; i_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; assert (wr_en === 1'b1)      else begin errors++; $error("FAIL hold_wr_en got %b want 1", wr_en); end
      checks++; assert (o_ready === 1'b0)    else begin errors++; $error("FAIL hold_o_ready got %b want 0", o_ready); end
      checks++; assert (wr_addr === 8'h20 && wr_data === 32'hA5A50F0F) else begin
        errors++; $error("FAIL hold_outputs got %02h/%08h want 20/a5a50f0f", wr_addr, wr_data);
      end
      @(posedge clk); #1;
    end
    wr_ready = 1'b1;
    send_byte(8'h00, 1'b1);
    idle(3);

    // Short frame, then a good one
    frm.delete(); frm.push_back(8'h01); frm.push_back(8'h10); frm.push_back(8'h78);
    expect_ev(EV_ERR, 8'h00, 32'h0, 2'd1);
    send_frame();
    build_write(8'h33, 32'hDEADBEEF);
    expect_ev(EV_WR, 8'h33, 32'hDEADBEEF, 2'd0);
    send_frame();
    idle(3);

    // Long frame drains to code 2
    build_write(8'h10, 32'h12345678);
    frm.push_back(8'hAA);
    expect_ev(EV_ERR, 8'h00, 32'h0, 2'd2);
    send_frame();
    idle(2);

    // Unknown opcode alone, and unknown opcode with trailing bytes
    frm.delete(); frm.push_back(8'h05);
    expect_ev(EV_ERR, 8'h00, 32'h0, 2'd3);
    send_frame();
    idle(2);
    frm.delete(); frm.push_back(8'h05); frm.push_back(8'h07); frm.push_back(8'h09);
    expect_ev(EV_ERR, 8'h00, 32'h0, 2'd3);
    send_frame();
    idle(2);

    // NOP
    frm.delete(); frm.push_back(8'h00);
    expect_ev(EV_NOP, 8'h00, 32'h0, 2'd0);
    send_frame();
    idle(2);

    // Reset mid-frame: no event, registers cleared, next byte is an opcode
    send_byte(8'h01, 1'b0);
    send_byte(8'h10, 1'b0);
    i_valid = 1'b0;
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    @(negedge clk);
    checks++; assert (wr_addr === 8'h00 && err_code === 2'd0) else begin
      errors++; $error("FAIL midrst_regs got %02h/%0d want 00/0", wr_addr, err_code);
    end
    @(posedge clk); #1;
    expect_ev(EV_NOP, 8'h00, 32'h0, 2'd0);
    send_byte(8'h00, 1'b1);
    idle(2);

`ifdef CMD_PARSER_CHECKSUM_EN
    // Corrupted checksum byte
    build_write(8'h10, 32'h12345678);
    frm[frm.size()-1] = frm[frm.size()-1] ^ 8'h2D;
    expect_ev(EV_ERR, 8'h00, 32'h0, 2'd3);
    send_frame();
    idle(2);
`endif

    idle(5);
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++; $error("FAIL pending_events got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Overall time limit
  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "time limit");
  end

endmodule
